// File: rtl/count_mon_pkg.sv
// Shared types for the count stream monitor: FSM states, step classes and
// the width of the upstream count.
package count_mon_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        STEP_ADV  = 2'd0,
        STEP_HOLD = 2'd1,
        STEP_ILL  = 2'd2
    } step_t;

endpackage

// File: rtl/count_step_classify.sv
// Pure combinational classification of one count step (previous sample vs
// current sample) into advance/hold/illegal, plus a 3->0 wrap flag.
module count_step_classify
    import count_mon_pkg::*;
(
    input  logic [CNT_W-1:0] prev_q,
    input  logic [CNT_W-1:0] cnt_in,
    output step_t            step,
    output logic             wrap
);

    logic [CNT_W-1:0] prev_inc;

    always_comb begin
        prev_inc = prev_q + CNT_W'(1);
        step     = STEP_ILL;
        if (cnt_in == prev_inc) begin
            step = STEP_ADV;
        end else if (cnt_in == prev_q) begin
            step = STEP_HOLD;
        end
        // Wrap is a special case of ADV, flagged separately for the wrap counter.
        wrap = (prev_q == '1) && (cnt_in == '0);
    end

endmodule

// File: rtl/count_stream_monitor.sv
// Monitors a free-running 2-bit count: tracks lock to the +1 sequence,
// counts wraps (3->0) and counts/flags illegal steps.
module count_stream_monitor
    import count_mon_pkg::*;
#(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4,
    parameter int LOCK_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              clr,
    output logic [WRAP_W-1:0] wraps,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              err,
    output logic              locked,
    output logic [1:0]        state
);

    // No valid/ready handshake: cnt_in is sampled unconditionally on every
    // rising edge, and every output is a register updated from that sample.

    mon_state_t        state_q, state_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [3:0]        run_q, run_d, run_inc;
    logic [WRAP_W-1:0] wraps_q, wraps_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_q, err_d;
    logic              err_evt, wrap_evt;

    step_t step;
    logic  wrap;

    count_step_classify u_classify (
        .prev_q (prev_q),
        .cnt_in (cnt_in),
        .step   (step),
        .wrap   (wrap)
    );

    always_comb begin
        state_d   = state_q;
        prev_d    = cnt_in;
        run_d     = run_q;
        wraps_d   = wraps_q;
        err_cnt_d = err_cnt_q;
        err_d     = err_q;
        err_evt   = 1'b0;
        wrap_evt  = 1'b0;
        run_inc   = run_q + 4'd1;

        case (state_q)
            ACQ: begin
                // First sample only seeds prev_q; nothing to compare against yet.
                state_d = TRACK;
                run_d   = '0;
            end
            TRACK: begin
                wrap_evt = wrap;
                case (step)
                    STEP_ADV: begin
                        run_d = run_inc;
                        if (run_inc == 4'(LOCK_N)) begin
                            state_d = LOCK;
                        end
                    end
                    STEP_ILL: begin
                        err_evt = 1'b1;
                        run_d   = '0;
                    end
                    default: ;
                endcase
            end
            LOCK: begin
                wrap_evt = wrap;
                if (step == STEP_ILL) begin
                    err_evt = 1'b1;
                    state_d = TRACK;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ACQ;
                run_d   = '0;
            end
        endcase

        if (wrap_evt) begin
            wraps_d = wraps_q + WRAP_W'(1);
        end
        if (err_evt) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end

        // Statistics clear wins over anything observed on the same edge.
        if (clr) begin
            state_d   = ACQ;
            prev_d    = '0;
            run_d     = '0;
            wraps_d   = '0;
            err_cnt_d = '0;
            err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACQ;
            prev_q    <= '0;
            run_q     <= '0;
            wraps_q   <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            run_q     <= run_d;
            wraps_q   <= wraps_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    assign wraps   = wraps_q;
    assign err_cnt = err_cnt_q;
    assign err     = err_q;
    assign locked  = (state_q == LOCK);
    assign state   = state_q;

endmodule
